// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one EXRAM port between two requesters, with fixed-latency read return.
// Define MEM_ARB_IO_DECODE_EN to serve addr >= IO_BASE internally (switch input, 7-seg latch); DATA_W must be >= 16.
module mem_port_arbiter #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] IO_BASE     = 16'hCFFD,
    parameter logic [ADDR_W-1:0] SWITCH_ADDR = 16'hCFFD,
    parameter logic [ADDR_W-1:0] SEG_ADDR    = 16'hCFFE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    input  logic [7:0]        switches,
    output logic [15:0]       seg_out,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    // Handshake: reqN is held with we/addr/wdata stable until gntN (a one-cycle
    // pulse) is seen; reqN high while idle is always a new request. rvalidN is a
    // one-cycle pulse qualifying the shared rdata bus.

    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;
    logic              sel_q, sel_d;
    logic              we_q, we_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_wren_q, mem_wren_d;
    logic              pick1;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // req0 wins a tie unless it was the last one served.
    assign pick1     = req1 && (!req0 || !last_q);
    assign sel_we    = pick1 ? we1 : we0;
    assign sel_addr  = pick1 ? addr1 : addr0;
    assign sel_wdata = pick1 ? wdata1 : wdata0;

`ifdef MEM_ARB_IO_DECODE_EN
    logic              io_q, io_d;
    logic [DATA_W-1:0] io_rdata_q, io_rdata_d;
    logic [15:0]       seg_q, seg_d;
    logic              sel_io;

    assign sel_io = (sel_addr >= IO_BASE);

    always_comb begin
        io_d       = io_q;
        io_rdata_d = io_rdata_q;
        seg_d      = seg_q;
        if (state_q == S_IDLE && (req0 || req1)) begin
            io_d = sel_io;
        end
        if (state_q == S_ISSUE && io_q) begin
            io_rdata_d = '0;
            if (mem_addr_q == SWITCH_ADDR) begin
                io_rdata_d[7:0] = switches;
            end else if (mem_addr_q == SEG_ADDR) begin
                io_rdata_d[15:0] = seg_q;
            end
            if (we_q && mem_addr_q == SEG_ADDR) begin
                seg_d = mem_data_q[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            io_q       <= 1'b0;
            io_rdata_q <= '0;
            seg_q      <= '0;
        end else begin
            io_q       <= io_d;
            io_rdata_q <= io_rdata_d;
            seg_q      <= seg_d;
        end
    end

    assign seg_out = seg_q;
`else
    logic unused_io_cfg;
    logic sel_io;
    logic io_q;
    logic [DATA_W-1:0] io_rdata_q;

    assign sel_io        = 1'b0;
    assign io_q          = 1'b0;
    assign io_rdata_q    = '0;
    assign seg_out       = 16'h0000;
    assign unused_io_cfg = ^{switches, IO_BASE, SWITCH_ADDR, SEG_ADDR};
`endif

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        sel_d      = sel_q;
        we_d       = we_q;
        rdata_d    = rdata_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        rvalid0_d  = 1'b0;
        rvalid1_d  = 1'b0;
        mem_wren_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    sel_d      = pick1;
                    last_d     = pick1;
                    we_d       = sel_we;
                    mem_addr_d = sel_addr;
                    mem_data_d = sel_wdata;
                    mem_wren_d = sel_we && !sel_io;
                    gnt0_d     = !pick1;
                    gnt1_d     = pick1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = we_q ? S_IDLE : S_RESP;
            end
            S_RESP: begin
                // EXRAM q_b is valid now, one cycle after the address was presented.
                rdata_d   = io_q ? io_rdata_q : mem_q;
                rvalid0_d = !sel_q;
                rvalid1_d = sel_q;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            last_q     <= 1'b1;
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata_q    <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_wren_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata_q    <= rdata_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_wren_q <= mem_wren_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign mem_wren  = mem_wren_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table for single transactions and IO, plus contention and reset sequences.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_IO_DECODE_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata, mem_addr, mem_data, mem_q;
    logic        mem_wren;
    logic [7:0]  switches;
    logic [15:0] seg_out;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_q[$];
    logic        exp_id_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q), .switches(switches), .seg_out(seg_out), .dbg_state(dbg_state)
    );

    // EXRAM port B model: registered read, one-cycle latency, plus a preload port.
    logic [15:0] ram [0:65535];
    logic        pre_we;
    logic [15:0] pre_addr, pre_data;

    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_wren) ram[mem_addr] <= mem_data;
        mem_q <= ram[mem_addr];
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        r0, r1, w0, w1;
        logic [15:0] a0, a1, d0, d1;
        logic [7:0]  sw;
        logic        g0, g1, v0, v1, wr;
        logic [15:0] rd, ma, seg;
    } vec_t;

    function automatic vec_t mk(input logic r0, r1, w0, w1, input logic [15:0] a0, a1, d0, d1,
                                input logic [7:0] sw, input logic g0, g1, v0, v1, wr,
                                input logic [15:0] rd, ma, seg);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.sw = sw;
        v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.wr = wr;
        v.rd = rd; v.ma = ma; v.seg = seg;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    vec_t tv[18];

    initial begin
        logic [15:0] seg_exp;
        logic [15:0] io_rd;
        int n_g, n_v, overlap;

        seg_exp = IO_EN ? 16'hA5C3 : 16'h0000;
        io_rd   = IO_EN ? 16'h005A : 16'h0000;

        //              r0 r1 w0 w1 a0        a1        d0 d1        sw      g0 g1 v0 v1 wr               rd        ma        seg
        tv[0]  = mk(1, 0, 0, 0, 16'h0010, 16'h0000, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 0,               16'h0000, 16'h0000, 16'h0000);
        tv[1]  = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 8'h00, 1, 0, 0, 0, 0,               16'h0000, 16'h0010, 16'h0000);
        tv[2]  = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 0,               16'h0000, 16'h0010, 16'h0000);
        tv[3]  = mk(0, 1, 0, 1, 16'h0000, 16'h0020, 0, 16'h1234, 8'h00, 0, 0, 1, 0, 0,               16'hBEEF, 16'h0010, 16'h0000);
        tv[4]  = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 8'h00, 0, 1, 0, 0, 1,               16'hBEEF, 16'h0020, 16'h0000);
        tv[5]  = mk(1, 0, 0, 0, 16'h0020, 16'h0000, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 0,               16'hBEEF, 16'h0020, 16'h0000);
        tv[6]  = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 8'h00, 1, 0, 0, 0, 0,               16'hBEEF, 16'h0020, 16'h0000);
        tv[7]  = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 0,               16'hBEEF, 16'h0020, 16'h0000);
        tv[8]  = mk(0, 1, 0, 1, 16'h0000, 16'hCFFE, 0, 16'hA5C3, 8'h00, 0, 0, 1, 0, 0,               16'h1234, 16'h0020, 16'h0000);
        tv[9]  = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 8'h00, 0, 1, 0, 0, IO_EN ? 1'b0 : 1'b1, 16'h1234, 16'hCFFE, 16'h0000);
        tv[10] = mk(1, 0, 0, 0, 16'hCFFD, 16'h0000, 0, 16'h0000, 8'h5A, 0, 0, 0, 0, 0,               16'h1234, 16'hCFFE, seg_exp);
        tv[11] = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 8'h5A, 1, 0, 0, 0, 0,               16'h1234, 16'hCFFD, seg_exp);
        tv[12] = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 8'h5A, 0, 0, 0, 0, 0,               16'h1234, 16'hCFFD, seg_exp);
        tv[13] = mk(0, 1, 0, 0, 16'h0000, 16'hCFFE, 0, 16'h0000, 8'h5A, 0, 0, 1, 0, 0,               io_rd,    16'hCFFD, seg_exp);
        tv[14] = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 8'h5A, 0, 1, 0, 0, 0,               io_rd,    16'hCFFE, seg_exp);
        tv[15] = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 8'h5A, 0, 0, 0, 0, 0,               io_rd,    16'hCFFE, seg_exp);
        tv[16] = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 8'h5A, 0, 0, 0, 1, 0,               16'hA5C3, 16'hCFFE, seg_exp);
        tv[17] = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 8'h5A, 0, 0, 0, 0, 0,               16'hA5C3, 16'hCFFE, seg_exp);

        // ---- reset with RAM preload ----
        reset = 1; switches = 8'h00; idle_inputs();
        pre_we = 1; pre_addr = 16'h0010; pre_data = 16'hBEEF;
        next_cycle();
        pre_addr = 16'hCFFD; pre_data = 16'h0000;
        next_cycle();
        pre_we = 0;
        @(negedge clk);
        chk("rst_gnt",     {gnt1, gnt0}, 0);
        chk("rst_rvalid",  {rvalid1, rvalid0}, 0);
        chk("rst_rdata",   rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_mem_wren", mem_wren, 0);
        chk("rst_seg_out", seg_out, 0);
        next_cycle();
        reset = 0;

        // ---- table: single read, write then read, IO write/read ----
        for (int i = 0; i < 18; i++) begin
            req0 = tv[i].r0; req1 = tv[i].r1; we0 = tv[i].w0; we1 = tv[i].w1;
            addr0 = tv[i].a0; addr1 = tv[i].a1; wdata0 = tv[i].d0; wdata1 = tv[i].d1;
            switches = tv[i].sw;
            @(negedge clk);
            chk($sformatf("v%0d_gnt0", i),     gnt0,     tv[i].g0);
            chk($sformatf("v%0d_gnt1", i),     gnt1,     tv[i].g1);
            chk($sformatf("v%0d_rvalid0", i),  rvalid0,  tv[i].v0);
            chk($sformatf("v%0d_rvalid1", i),  rvalid1,  tv[i].v1);
            chk($sformatf("v%0d_mem_wren", i), mem_wren, tv[i].wr);
            chk($sformatf("v%0d_rdata", i),    rdata,    tv[i].rd);
            chk($sformatf("v%0d_mem_addr", i), mem_addr, tv[i].ma);
            chk($sformatf("v%0d_seg_out", i),  seg_out,  tv[i].seg);
            next_cycle();
        end

        // ---- contention: both held, six reads, grants must alternate from req0 ----
        reset = 1; idle_inputs();
        next_cycle();
        reset = 0;
        req0 = 1; req1 = 1; addr0 = 16'h0010; addr1 = 16'h0020;
        n_g = 0; n_v = 0; overlap = 0;
        for (int cyc = 0; cyc < 60 && n_v < 6; cyc++) begin
            @(negedge clk);
            if (gnt0 && gnt1) overlap++;
            if (rvalid0 && rvalid1) overlap++;
            if (gnt0 || gnt1) begin
                chk($sformatf("rr_gnt_%0d_id", n_g), {31'd0, gnt1}, n_g % 2);
                exp_q.push_back(gnt1 ? 16'h1234 : 16'hBEEF);
                exp_id_q.push_back(gnt1);
                n_g++;
                if (n_g == 6) begin req0 = 0; req1 = 0; end
            end
            if (rvalid0 || rvalid1) begin
                if (exp_q.size() == 0) begin
                    chk("rr_spurious_rvalid", 1, 0);
                end else begin
                    chk($sformatf("rr_rdata_%0d", n_v), rdata, exp_q.pop_front());
                    chk($sformatf("rr_rvalid_%0d_id", n_v), {31'd0, rvalid1}, {31'd0, exp_id_q.pop_front()});
                end
                n_v++;
            end
            next_cycle();
        end
        chk("rr_grant_count",  n_g, 6);
        chk("rr_rvalid_count", n_v, 6);
        chk("rr_overlap",      overlap, 0);

        // ---- reset during ISSUE of a read ----
        idle_inputs();
        req0 = 1; addr0 = 16'h0010;
        @(negedge clk);
        next_cycle();
        req0 = 0;
        @(negedge clk);
        chk("ri_gnt0_before_reset", gnt0, 1);
        reset = 1;
        next_cycle();
        @(negedge clk);
        chk("ri_gnt",      {gnt1, gnt0}, 0);
        chk("ri_rvalid",   {rvalid1, rvalid0}, 0);
        chk("ri_rdata",    rdata, 0);
        chk("ri_mem_addr", mem_addr, 0);
        chk("ri_mem_wren", mem_wren, 0);
        chk("ri_seg_out",  seg_out, 0);
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk);
            chk($sformatf("ri_no_rvalid_%0d", i), {rvalid1, rvalid0}, 0);
        end
        next_cycle();
        req0 = 1; addr0 = 16'h0020;
        @(negedge clk);
        next_cycle();
        req0 = 0;
        @(negedge clk);
        chk("ri_after_gnt0", {gnt1, gnt0}, 2'b01);
        chk("ri_after_addr", mem_addr, 16'h0020);
        next_cycle();
        @(negedge clk);
        chk("ri_after_early_rvalid", {rvalid1, rvalid0}, 0);
        next_cycle();
        @(negedge clk);
        chk("ri_after_rvalid0", {rvalid1, rvalid0}, 2'b01);
        chk("ri_after_rdata", rdata, 16'h1234);

        // ---- report ----
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
